// File: rtl/mem_clk_rst_seq.sv
// mem_clk_rst_seq: power-up / lock sequencer for the memory-clock PLL.
// Runs on the PLL reference clock. It pulses the PLL reset, waits for a
// stable lock, then enables CLKOUT0 and later releases the memory-domain reset.
// Optional feature macro: MEM_CLK_LOCK_LOSS_CNT_EN adds a saturating
// lock-loss event counter on the lock_loss_cnt port.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_PLL_RST   | pll_rst pulse in progress (PLL_RST_CYC cycles)
// S_WAIT_LOCK | PLL out of reset, waiting for lock_s, timeout window running
// S_STABLE    | lock_s seen, must stay high LOCK_STABLE_CYC cycles
// S_CLK_EN    | CLKOUT0 enabled, mem_rst still held for ENCLK_TO_RST_CYC
// S_RUN       | clock stable, mem_rst released, ready=1
// S_FAIL      | retries exhausted, terminal until rst

module mem_clk_rst_seq #(
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int ENCLK_TO_RST_CYC = 64,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int PLL_RST_CYC      = 16,
   parameter int MAX_RETRY        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lock,
   output logic       pll_rst,
   output logic       enclk0,
   output logic       mem_rst,
   output logic       ready,
   output logic       fail
`ifdef MEM_CLK_LOCK_LOSS_CNT_EN
   ,
   output logic [7:0] lock_loss_cnt
`endif
);

   localparam int MAX_A   = (LOCK_STABLE_CYC > ENCLK_TO_RST_CYC) ? LOCK_STABLE_CYC : ENCLK_TO_RST_CYC;
   localparam int MAX_B   = (LOCK_TIMEOUT_CYC > PLL_RST_CYC) ? LOCK_TIMEOUT_CYC : PLL_RST_CYC;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_CLK_EN,
      S_RUN,
      S_FAIL
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [RETRY_W-1:0] retry, retry_nx;
   logic               lock_m, lock_s;
   logic               loss_evt;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= lock;
         lock_s <= lock_m;
      end
   end

   // Next-state, retry and shared-counter logic.
   always_comb begin
      state_nx = state;
      retry_nx = retry;
      loss_evt = 1'b0;
      case (state)
         S_PLL_RST: begin
            if (cnt == CNT_W'(PLL_RST_CYC - 1))
               state_nx = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            // a lock arriving on the timeout cycle takes priority over the retry
            if (lock_s)
               state_nx = S_STABLE;
            else if (cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
               if (retry < RETRY_W'(MAX_RETRY)) begin
                  retry_nx = retry + 1'b1;
                  state_nx = S_PLL_RST;
               end else begin
                  state_nx = S_FAIL;
               end
            end
         end
         S_STABLE: begin
            if (!lock_s)
               state_nx = S_WAIT_LOCK;
            else if (cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
               state_nx = S_CLK_EN;
               retry_nx = '0;
            end
         end
         S_CLK_EN: begin
            // loss of lock beats the CLK_EN exit on the same cycle
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               loss_evt = 1'b1;
            end else if (cnt == CNT_W'(ENCLK_TO_RST_CYC - 1))
               state_nx = S_RUN;
         end
         S_RUN: begin
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               loss_evt = 1'b1;
            end
         end
         S_FAIL: state_nx = S_FAIL;
         default: state_nx = S_PLL_RST;
      endcase

      if (state_nx != state)
         cnt_nx = '0;
      else if (state == S_RUN || state == S_FAIL)
         cnt_nx = cnt;
      else
         cnt_nx = cnt + 1'b1;
   end

   // State register plus outputs registered from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_PLL_RST;
         cnt     <= '0;
         retry   <= '0;
         pll_rst <= 1'b1;
         enclk0  <= 1'b0;
         mem_rst <= 1'b1;
         ready   <= 1'b0;
         fail    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         retry   <= retry_nx;
         pll_rst <= (state_nx == S_PLL_RST);
         enclk0  <= (state_nx == S_CLK_EN) || (state_nx == S_RUN);
         mem_rst <= (state_nx != S_RUN);
         ready   <= (state_nx == S_RUN);
         fail    <= (state_nx == S_FAIL);
      end
   end

`ifdef MEM_CLK_LOCK_LOSS_CNT_EN
   // Saturating count of lock losses seen after the clock was enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lock_loss_cnt <= 8'd0;
      else if (loss_evt && (lock_loss_cnt != 8'hFF))
         lock_loss_cnt <= lock_loss_cnt + 8'd1;
   end
`endif

endmodule
